// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and limits for the stopwatch controller
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

  localparam int         DEFAULT_TICK_DIV = 10;
  localparam logic [5:0] SEC_MAX          = 6'd59;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - rising-edge detector for one button level
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic r_prev;

  // History resets high so a button held through reset yields no event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= btn;
    end
  end

  assign rise = btn & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch FSM, tick prescaler and lap capture registers
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int MAX_MIN  = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       lap,
  input  logic       clear,
  input  logic [5:0] seconds,
  input  logic [6:0] minutes,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [1:0] state,
  output logic       lap_valid,
  output logic [5:0] lap_sec,
  output logic [6:0] lap_min,
  output logic       done
);

  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
  localparam logic [6:0]  MIN_LAST  = 7'(MAX_MIN);

  logic w_start_ev, w_stop_ev, w_lap_ev, w_clear_ev;

  btn_edge u_start_edge (.clk(clk), .rst(rst), .btn(start), .rise(w_start_ev));
  btn_edge u_stop_edge  (.clk(clk), .rst(rst), .btn(stop),  .rise(w_stop_ev));
  btn_edge u_lap_edge   (.clk(clk), .rst(rst), .btn(lap),   .rise(w_lap_ev));
  btn_edge u_clear_edge (.clk(clk), .rst(rst), .btn(clear), .rise(w_clear_ev));

  state_t      r_state, w_state_nxt;
  logic [23:0] r_presc, w_presc_nxt;
  logic        r_cnt_en, w_cnt_en_nxt;
  logic        r_cnt_clr, w_cnt_clr_nxt;
  logic        r_lap_valid, w_lap_valid_nxt;
  logic [5:0]  r_lap_sec, w_lap_sec_nxt;
  logic [6:0]  r_lap_min, w_lap_min_nxt;

  logic w_tick, w_sat;

  assign w_tick = (r_presc == TICK_LAST);
  assign w_sat  = (seconds == SEC_MAX) && (minutes == MIN_LAST);

  // Event priority is the order of this if/else chain: clear, stop, start, then lap/count.
  always_comb begin
    w_state_nxt     = r_state;
    w_presc_nxt     = r_presc;
    w_cnt_en_nxt    = 1'b0;
    w_cnt_clr_nxt   = 1'b0;
    w_lap_valid_nxt = r_lap_valid;
    w_lap_sec_nxt   = r_lap_sec;
    w_lap_min_nxt   = r_lap_min;
    if (w_clear_ev) begin
      w_state_nxt     = ST_IDLE;
      w_presc_nxt     = 24'd0;
      w_cnt_clr_nxt   = 1'b1;
      w_lap_valid_nxt = 1'b0;
      w_lap_sec_nxt   = 6'd0;
      w_lap_min_nxt   = 7'd0;
    end else if (w_stop_ev && (r_state == ST_RUNNING)) begin
      w_state_nxt = ST_PAUSED;
    end else if (w_start_ev && ((r_state == ST_IDLE) || (r_state == ST_PAUSED))) begin
      w_state_nxt = ST_RUNNING;
      if (r_state == ST_IDLE) begin
        w_presc_nxt = 24'd0;
      end
    end else if (r_state == ST_RUNNING) begin
      if (w_lap_ev) begin
        w_lap_valid_nxt = 1'b1;
        w_lap_sec_nxt   = seconds;
        w_lap_min_nxt   = minutes;
      end
      if (w_tick) begin
        w_presc_nxt = 24'd0;
        // At MAX_MIN:59 the tick becomes the transition to DONE instead of an increment.
        if (w_sat) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_en_nxt = 1'b1;
        end
      end else begin
        w_presc_nxt = r_presc + 24'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_presc     <= 24'd0;
      r_cnt_en    <= 1'b0;
      r_cnt_clr   <= 1'b0;
      r_lap_valid <= 1'b0;
      r_lap_sec   <= 6'd0;
      r_lap_min   <= 7'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_cnt_en    <= w_cnt_en_nxt;
      r_cnt_clr   <= w_cnt_clr_nxt;
      r_lap_valid <= w_lap_valid_nxt;
      r_lap_sec   <= w_lap_sec_nxt;
      r_lap_min   <= w_lap_min_nxt;
    end
  end

  assign cnt_en    = r_cnt_en;
  assign cnt_clr   = r_cnt_clr;
  assign state     = r_state;
  assign lap_valid = r_lap_valid;
  assign lap_sec   = r_lap_sec;
  assign lap_min   = r_lap_min;
  assign done      = (r_state == ST_DONE);

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10: clock cycles per counting tick; legal range 2..2^24.
REQ-002 SHALL have parameter MAX_MIN, default 99: highest minutes value before saturation; legal range 1..127.
REQ-003 SHALL have a single clock and a synchronous active-high reset; port `clk` is the clock (input, 1 bit, rising edge). No other clock exists.
REQ-004 SHALL have port `rst`: input, 1 bit, synchronous, active-high.
REQ-005 SHALL have port `start`: input, 1 bit, synchronous level button; the rising edge is the event.
REQ-006 SHALL have port `stop`: input, 1 bit, rising edge is the event.
REQ-007 SHALL have port `lap`: input, 1 bit, rising edge is the event.
REQ-008 SHALL have port `clear`: input, 1 bit, rising edge is the event.
REQ-009 SHALL have port `seconds`: input, 6 bits, current seconds from the counter datapath (0..59).
REQ-010 SHALL have port `minutes`: input, 7 bits, current minutes from the counter datapath.
REQ-011 SHALL have port `cnt_en`: output, 1 bit, one-cycle increment pulse to the datapath.
REQ-012 SHALL have port `cnt_clr`: output, 1 bit, one-cycle clear pulse to the datapath.
REQ-013 SHALL have port `state`: output, 2 bits, current FSM state code.
REQ-014 SHALL have port `lap_valid`: output, 1 bit; high while the lap registers hold a capture.
REQ-015 SHALL have port `lap_sec`: output, 6 bits, captured seconds.
REQ-016 SHALL have port `lap_min`: output, 7 bits, captured minutes.
REQ-017 SHALL have port `done`: output, 1 bit; high in state DONE.

Function
REQ-018 SHALL register the previous value of each button; an event = current 1 AND previous 0. The FSM SHALL act on the same clock edge that detects the event.
REQ-019 SHALL implement the states IDLE=00, RUNNING=01, PAUSED=10 and DONE=11.
REQ-020 SHALL resolve simultaneous events with priority clear > stop > start > lap. Only the highest-priority applicable event acts in a cycle.
REQ-021 clear in any state SHALL: go to IDLE, pulse cnt_clr for 1 cycle, zero the prescaler, and drop lap_valid. lap_sec and lap_min are zeroed at the same time.
REQ-022 start in IDLE SHALL go to RUNNING with the prescaler zeroed.
REQ-023 start in PAUSED SHALL go to RUNNING with the prescaler value retained, so resume keeps the fractional tick.
REQ-024 stop in RUNNING SHALL go to PAUSED and freeze the prescaler.
REQ-025 start in RUNNING or DONE SHALL be ignored.
REQ-026 stop in IDLE, PAUSED or DONE SHALL be ignored.
REQ-027 Prescaler (24 bits) SHALL count 0..TICK_DIV-1 only in RUNNING and wrap to 0.
REQ-028 cnt_en SHALL be high for exactly the cycle in which the prescaler equals TICK_DIV-1 in RUNNING, unless REQ-029 applies.
REQ-029 Saturation: if a tick would occur while seconds==59 and minutes==MAX_MIN, cnt_en SHALL stay 0 and the FSM SHALL go to DONE; the count stays at MAX_MIN:59.
REQ-030 DONE SHALL be exited only by clear or rst.
REQ-031 lap in RUNNING SHALL copy seconds and minutes into lap_sec and lap_min and set lap_valid; the copy is overwritten on each new lap.
REQ-032 If lap coincides with cnt_en, the lap registers SHALL hold the pre-increment input values.
REQ-033 lap in IDLE, PAUSED or DONE SHALL be ignored.
REQ-034 stop or clear arriving in the same cycle as a would-be tick SHALL suppress that cnt_en.
REQ-035 All outputs SHALL be registered or decoded directly from registers; there is no combinational path from any input to any output.

Reset
REQ-036 rst SHALL dominate all events.
REQ-037 On rst: state=IDLE, prescaler=0, cnt_en=0, cnt_clr=0, lap_valid=0, lap_sec=0, lap_min=0, done=0.
REQ-038 On rst: all button-history registers SHALL be set to 1, so a button held through reset produces no event.
REQ-039 rst asserted mid-RUNNING SHALL take effect at the next clock edge; the datapath is reset by its own rst input.

Structure
REQ-040 Package stopwatch_pkg SHALL hold the state encoding constants, DEFAULT_TICK_DIV and SEC_MAX=59.
REQ-041 Sub-module btn_edge (1-bit history register plus rising-edge output, reset-high history) SHALL be instantiated once per button.
REQ-042 The FSM, prescaler and lap registers SHALL reside in stopwatch_ctrl.

Verification (TICK_DIV=4, MAX_MIN=1, datapath model attached)
REQ-043 Reset, start pulse, run 16 cycles -> state=01, cnt_en pulses every 4th cycle, 4 pulses total.
REQ-044 Run 6 cycles (prescaler=2), stop, hold 20 cycles, start -> no cnt_en while paused; first cnt_en 2 cycles after resume.
REQ-045 lap while count is 00:07 and coincident with cnt_en -> lap_sec=7, lap_min=0, lap_valid=1; a lap in PAUSED leaves them unchanged.
REQ-046 start, stop and clear rise together in RUNNING -> cnt_clr pulses 1 cycle, state=00, lap_valid=0.
REQ-047 Run to 01:59, then the next tick -> cnt_en stays 0, done=1, state=11; start and stop ignored; clear -> IDLE.
REQ-048 Hold start high through reset release -> no transition until start falls and rises again.
